key_check_sequencer: RTL and testbench

Request sequencer directly upstream of the key verifier in the datapath verification path. It accepts a wallet-access request (account index plus the 8-bit private input key) and looks up that account's 11-bit public key in an internal key table. It then drives the verifier with a start pulse, waits for the verdict or a timeout, and returns a grant/deny response. It also enforces per-account lockout after repeated failures.

---
 rtl/key_check_sequencer_pkg.sv | 33 +++
 rtl/key_check_sequencer_key_table.sv | 57 +++++
 rtl/key_check_sequencer.sv | 138 +++++++++++++
 tb/tb_key_check_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_check_sequencer_pkg.sv
// rtl/key_check_sequencer_pkg.sv - shared types and constants for the key check sequencer
package key_check_sequencer_pkg;

  localparam int PK_W   = 11;
  localparam int IK_W   = 8;
  localparam int FCNT_W = 3;

  localparam logic [2:0] KEY_TAG_VALID = 3'b010;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_EMPTY   = 2'b01,
    ERR_LOCKED  = 2'b10,
    ERR_TIMEOUT = 2'b11
  } resp_err_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RESPOND = 3'd4
  } seq_state_t;

  function automatic logic [FCNT_W-1:0] fail_cnt_inc(input logic [FCNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  function automatic logic key_is_valid(input logic [PK_W-1:0] pk);
    return pk[PK_W-1 -: 3] == KEY_TAG_VALID;
  endfunction

endpackage

// File: rtl/key_check_sequencer_key_table.sv
// rtl/key_check_sequencer_key_table.sv - per-account public key store with fail counting and lockout
module key_check_sequencer_key_table
  import key_check_sequencer_pkg::*;
#(
  parameter int ACCOUNTS  = 4,
  parameter int ACCT_W    = 2,
  parameter int MAX_FAILS = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [ACCT_W-1:0] wr_account,
  input  logic [PK_W-1:0]   wr_public_key,
  input  logic [ACCT_W-1:0] rd_account,
  output logic [PK_W-1:0]   rd_public_key,
  output logic              rd_locked,
  input  logic              fail_clr,
  input  logic              fail_inc,
  input  logic [ACCT_W-1:0] fail_account
);

  localparam logic [FCNT_W-1:0] MAX_FAILS_C = FCNT_W'(MAX_FAILS);

  logic [PK_W-1:0]   pk_q   [ACCOUNTS];
  logic [FCNT_W-1:0] fcnt_q [ACCOUNTS];
  logic              lock_q [ACCOUNTS];

  assign rd_public_key = pk_q[rd_account];
  assign rd_locked     = lock_q[rd_account];

  // A key write to an entry overrides any fail update aimed at it in the same cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ACCOUNTS; i++) begin
        pk_q[i]   <= '0;
        fcnt_q[i] <= '0;
        lock_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < ACCOUNTS; i++) begin
        if (wr_en && wr_account == ACCT_W'(i)) begin
          pk_q[i]   <= wr_public_key;
          fcnt_q[i] <= '0;
          lock_q[i] <= 1'b0;
        end else if (fail_account == ACCT_W'(i)) begin
          if (fail_clr) begin
            fcnt_q[i] <= '0;
          end else if (fail_inc) begin
            fcnt_q[i] <= fail_cnt_inc(fcnt_q[i]);
            if (fail_cnt_inc(fcnt_q[i]) >= MAX_FAILS_C) lock_q[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/key_check_sequencer.sv
// rtl/key_check_sequencer.sv - request sequencer driving the key verifier with timeout and lockout
module key_check_sequencer
  import key_check_sequencer_pkg::*;
#(
  parameter int ACCOUNTS  = 4,
  parameter int ACCT_W    = 2,
  parameter int TIMEOUT   = 15,
  parameter int MAX_FAILS = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ACCT_W-1:0] req_account,
  input  logic [IK_W-1:0]   req_key,
  input  logic              wr_en,
  input  logic [ACCT_W-1:0] wr_account,
  input  logic [PK_W-1:0]   wr_public_key,
  output logic              vk_start,
  output logic [PK_W-1:0]   vk_public_key,
  output logic [IK_W-1:0]   vk_input_key,
  input  logic              vk_done,
  input  logic              vk_correct,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_grant,
  output logic [1:0]        resp_error,
  output logic [ACCT_W-1:0] resp_account
);

  seq_state_t        state;
  logic [ACCT_W-1:0] acct_q;
  logic [7:0]        wait_cnt;
  logic [PK_W-1:0]   rd_public_key;
  logic              rd_locked;
  logic              timeout_hit;
  logic              fail_clr;
  logic              fail_inc;

  assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));
  // Fail bookkeeping lands on the same edge that moves WAIT into RESPOND.
  assign fail_clr = (state == ST_WAIT) && vk_done && vk_correct;
  assign fail_inc = (state == ST_WAIT) && (vk_done ? !vk_correct : timeout_hit);

  key_check_sequencer_key_table #(
    .ACCOUNTS  (ACCOUNTS),
    .ACCT_W    (ACCT_W),
    .MAX_FAILS (MAX_FAILS)
  ) u_table (
    .clock         (clock),
    .resetn        (resetn),
    .wr_en         (wr_en),
    .wr_account    (wr_account),
    .wr_public_key (wr_public_key),
    .rd_account    (acct_q),
    .rd_public_key (rd_public_key),
    .rd_locked     (rd_locked),
    .fail_clr      (fail_clr),
    .fail_inc      (fail_inc),
    .fail_account  (acct_q)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      acct_q        <= '0;
      wait_cnt      <= '0;
      req_ready     <= 1'b0;
      vk_start      <= 1'b0;
      vk_public_key <= '0;
      vk_input_key  <= '0;
      resp_valid    <= 1'b0;
      resp_grant    <= 1'b0;
      resp_error    <= ERR_NONE;
      resp_account  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            acct_q       <= req_account;
            vk_input_key <= req_key;
            req_ready    <= 1'b0;
            state        <= ST_LOOKUP;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_LOOKUP: begin
          vk_public_key <= rd_public_key;
          resp_account  <= acct_q;
          if (!key_is_valid(rd_public_key)) begin
            resp_valid <= 1'b1;
            resp_grant <= 1'b0;
            resp_error <= ERR_EMPTY;
            state      <= ST_RESPOND;
          end else if (rd_locked) begin
            resp_valid <= 1'b1;
            resp_grant <= 1'b0;
            resp_error <= ERR_LOCKED;
            state      <= ST_RESPOND;
          end else begin
            vk_start <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          vk_start <= 1'b0;
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (vk_done) begin
            resp_valid <= 1'b1;
            resp_grant <= vk_correct;
            resp_error <= ERR_NONE;
            state      <= ST_RESPOND;
          end else if (timeout_hit) begin
            resp_valid <= 1'b1;
            resp_grant <= 1'b0;
            resp_error <= ERR_TIMEOUT;
            state      <= ST_RESPOND;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_RESPOND: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_check_sequencer.sv
// tb/tb_key_check_sequencer.sv - directed self-checking bench for key_check_sequencer
module tb_key_check_sequencer;

  logic        clock = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_account;
  logic [7:0]  req_key;
  logic        wr_en;
  logic [1:0]  wr_account;
  logic [10:0] wr_public_key;
  logic        vk_start;
  logic [10:0] vk_public_key;
  logic [7:0]  vk_input_key;
  logic        vk_done;
  logic        vk_correct;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_grant;
  logic [1:0]  resp_error;
  logic [1:0]  resp_account;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clock = ~clock;

  key_check_sequencer #(
    .ACCOUNTS (4), .ACCT_W (2), .TIMEOUT (15), .MAX_FAILS (3)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_account   (req_account),
    .req_key       (req_key),
    .wr_en         (wr_en),
    .wr_account    (wr_account),
    .wr_public_key (wr_public_key),
    .vk_start      (vk_start),
    .vk_public_key (vk_public_key),
    .vk_input_key  (vk_input_key),
    .vk_done       (vk_done),
    .vk_correct    (vk_correct),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_grant    (resp_grant),
    .resp_error    (resp_error),
    .resp_account  (resp_account)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic cycle_to(input int n);
    while (cyc < n) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic write_key(input logic [1:0] a, input logic [10:0] pk);
    wr_en = 1'b1; wr_account = a; wr_public_key = pk;
    @(posedge clock); #1;
    wr_en = 1'b0;
    @(negedge clock);
    cyc++;
  endtask

  task automatic issue(input logic [1:0] a, input logic [7:0] k);
    int n = 0;
    @(negedge clock);
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("issue_ready_seen", 32'(req_ready), 1);
    req_valid = 1'b1; req_account = a; req_key = k;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    cyc = 1;
  endtask

  task automatic done_pulse(input logic correct);
    vk_done = 1'b1; vk_correct = correct;
    @(posedge clock); #1;
    vk_done = 1'b0; vk_correct = 1'b0;
    @(negedge clock);
    cyc++;
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_account = '0; req_key = '0;
    wr_en = 1'b0; wr_account = '0; wr_public_key = '0;
    vk_done = 1'b0; vk_correct = 1'b0; resp_ready = 1'b0;

    repeat (2) @(negedge clock);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_vk_start", 32'(vk_start), 0);
    check("rst_vk_pk", 32'(vk_public_key), 0);
    check("rst_vk_ik", 32'(vk_input_key), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_resp_grant", 32'(resp_grant), 0);
    check("rst_resp_error", 32'(resp_error), 0);
    check("rst_resp_account", 32'(resp_account), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_req_ready", 32'(req_ready), 1);

    // Correct key on account 1, verdict three cycles after start
    write_key(2'd1, 11'h25A);
    issue(2'd1, 8'h33);
    check("t1_c1_start", 32'(vk_start), 0);
    check("t1_c1_ready", 32'(req_ready), 0);
    cycle_to(2);
    check("t1_c2_start", 32'(vk_start), 1);
    check("t1_c2_pk", 32'(vk_public_key), 'h25A);
    check("t1_c2_ik", 32'(vk_input_key), 'h33);
    cycle_to(3);
    check("t1_c3_start", 32'(vk_start), 0);
    check("t1_c3_valid", 32'(resp_valid), 0);
    cycle_to(5);
    done_pulse(1'b1);
    check("t1_valid", 32'(resp_valid), 1);
    check("t1_grant", 32'(resp_grant), 1);
    check("t1_error", 32'(resp_error), 0);
    check("t1_account", 32'(resp_account), 1);
    check("t1_fcnt", 32'(dut.u_table.fcnt_q[1]), 0);
    consume();

    // Unwritten account reports empty without starting the verifier
    issue(2'd2, 8'h11);
    check("t2_c1_start", 32'(vk_start), 0);
    cycle_to(2);
    check("t2_start", 32'(vk_start), 0);
    check("t2_valid", 32'(resp_valid), 1);
    check("t2_grant", 32'(resp_grant), 0);
    check("t2_error", 32'(resp_error), 1);
    check("t2_account", 32'(resp_account), 2);
    consume();

    // Three mismatches lock account 1
    for (int i = 1; i <= 3; i++) begin
      issue(2'd1, 8'h44);
      cycle_to(5);
      done_pulse(1'b0);
      check("t3_valid", 32'(resp_valid), 1);
      check("t3_grant", 32'(resp_grant), 0);
      check("t3_error", 32'(resp_error), 0);
      check("t3_fcnt", 32'(dut.u_table.fcnt_q[1]), 32'(i));
      consume();
    end
    check("t3_locked", 32'(dut.u_table.lock_q[1]), 1);
    issue(2'd1, 8'h33);
    check("t3_lk_c1_start", 32'(vk_start), 0);
    cycle_to(2);
    check("t3_lk_start", 32'(vk_start), 0);
    check("t3_lk_valid", 32'(resp_valid), 1);
    check("t3_lk_error", 32'(resp_error), 2);
    consume();

    // Rewriting the key unlocks the account
    @(negedge clock);
    write_key(2'd1, 11'h25A);
    issue(2'd1, 8'h33);
    cycle_to(5);
    done_pulse(1'b1);
    check("t3_rw_grant", 32'(resp_grant), 1);
    check("t3_rw_error", 32'(resp_error), 0);
    check("t3_rw_fcnt", 32'(dut.u_table.fcnt_q[1]), 0);
    consume();

    // Write coinciding with a mismatch: write wins, in-flight key unchanged
    issue(2'd1, 8'h55);
    cycle_to(5);
    wr_en = 1'b1; wr_account = 2'd1; wr_public_key = 11'h2C3;
    done_pulse(1'b0);
    wr_en = 1'b0;
    check("t4_valid", 32'(resp_valid), 1);
    check("t4_grant", 32'(resp_grant), 0);
    check("t4_vk_pk_held", 32'(vk_public_key), 'h25A);
    check("t4_vk_ik_held", 32'(vk_input_key), 'h55);
    check("t4_fcnt_dropped", 32'(dut.u_table.fcnt_q[1]), 0);
    check("t4_pk_written", 32'(dut.u_table.pk_q[1]), 'h2C3);
    consume();

    // Timeout; a done pulse during ISSUE must be ignored
    issue(2'd1, 8'h33);
    cycle_to(2);
    check("t5_start", 32'(vk_start), 1);
    done_pulse(1'b1);
    cycle_to(17);
    check("t5_c17_valid", 32'(resp_valid), 0);
    cycle_to(18);
    check("t5_valid", 32'(resp_valid), 1);
    check("t5_grant", 32'(resp_grant), 0);
    check("t5_error", 32'(resp_error), 3);
    check("t5_account", 32'(resp_account), 1);
    check("t5_pk", 32'(vk_public_key), 'h2C3);
    check("t5_fcnt", 32'(dut.u_table.fcnt_q[1]), 1);
    consume();

    // Response backpressure with a competing request
    issue(2'd3, 8'h01);
    cycle_to(2);
    req_valid = 1'b1; req_account = 2'd0; req_key = 8'hEE;
    for (int c = 2; c <= 6; c++) begin
      cycle_to(c);
      check("t6_valid", 32'(resp_valid), 1);
      check("t6_error", 32'(resp_error), 1);
      check("t6_account", 32'(resp_account), 3);
      check("t6_req_ready", 32'(req_ready), 0);
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0; req_valid = 1'b0;
    @(negedge clock);
    cyc++;
    check("t6_idle_ready", 32'(req_ready), 1);
    check("t6_idle_valid", 32'(resp_valid), 0);
    check("t6_ik_unchanged", 32'(vk_input_key), 'h01);

    // Reset during WAIT aborts and clears the table
    issue(2'd1, 8'h33);
    cycle_to(4);
    resetn = 1'b0;
    #1;
    check("t7_rst_valid", 32'(resp_valid), 0);
    check("t7_rst_ready", 32'(req_ready), 0);
    check("t7_rst_pk", 32'(dut.u_table.pk_q[1]), 0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    check("t7_post_valid", 32'(resp_valid), 0);
    issue(2'd1, 8'h33);
    cycle_to(2);
    check("t7_valid", 32'(resp_valid), 1);
    check("t7_error", 32'(resp_error), 1);
    check("t7_start", 32'(vk_start), 0);
    consume();

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
